// File: rtl/latch_bank_controller_pkg.sv
// Shared types and constants for the latch bank controller.
package latch_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        OPEN,
        CLOSE,
        ACK
    } state_t;

    localparam int OPEN_CNT_W = 4;

endpackage

// File: rtl/latch_bank_controller_if.sv
// Requester-side bus of the latch bank controller: two level requests with address, data and ack.
interface latch_bank_controller_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
);
    logic             req0;
    logic             req1;
    logic [AW-1:0]    addr0;
    logic [AW-1:0]    addr1;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic             ack0;
    logic             ack1;

    modport master (
        output req0, req1, addr0, addr1, data0, data1,
        input  ack0, ack1
    );

    modport slave (
        input  req0, req1, addr0, addr1, data0, data1,
        output ack0, ack1
    );
endinterface

// File: rtl/latch_bank_controller_arb.sv
// Two-way round-robin pick; on a tie the requester that is not last_grant wins.
// Latency: combinational. Backpressure: none, the caller decides when to consume the pick.
module rr_arbiter2 (
    input  logic req0,
    input  logic req1,
    input  logic grant,
    output logic valid,
    output logic winner
);
    always_comb begin
        valid  = req0 | req1;
        winner = (req0 & req1) ? ~grant : req1;
    end
endmodule

// File: rtl/latch_bank_controller.sv
// Arbitrates two writers onto a transparent latch bank, sequencing data bus and enables safely.
// Latency: ack OPEN_CYCLES+3 cycles after grant; backpressure: req held until ack, one write in flight.
module latch_bank_controller
    import latch_ctrl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int OPEN_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    latch_bank_controller_if.slave req_if,
    output logic [DEPTH-1:0]       latch_en,
    output logic [WIDTH-1:0]       latch_d,
    output logic                   busy,
    output logic                   grant
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t                state, state_n;
    logic [OPEN_CNT_W-1:0] cnt, cnt_n;
    logic [AW-1:0]         cap_addr, cap_addr_n;
    logic [DEPTH-1:0]      en_dec;
    logic [DEPTH-1:0]      latch_en_n;
    logic [WIDTH-1:0]      latch_d_n;
    logic                  ack0_n, ack1_n, busy_n, grant_n;
    logic                  arb_valid, arb_winner;

    rr_arbiter2 u_arb (
        .req0   (req_if.req0),
        .req1   (req_if.req1),
        .grant  (grant),
        .valid  (arb_valid),
        .winner (arb_winner)
    );

    // Out-of-range addresses decode to no enable at all.
    always_comb begin
        en_dec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cap_addr == AW'(i)) begin
                en_dec[i] = 1'b1;
            end
        end
    end

    // Outputs are computed for the state being entered so they come straight from flops.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        cap_addr_n = cap_addr;
        grant_n    = grant;
        latch_d_n  = latch_d;
        latch_en_n = '0;
        ack0_n     = 1'b0;
        ack1_n     = 1'b0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_n    = SETUP;
                    grant_n    = arb_winner;
                    cap_addr_n = arb_winner ? req_if.addr1 : req_if.addr0;
                    latch_d_n  = arb_winner ? req_if.data1 : req_if.data0;
                end
            end
            SETUP: begin
                state_n    = OPEN;
                cnt_n      = OPEN_CNT_W'(OPEN_CYCLES - 1);
                latch_en_n = en_dec;
            end
            OPEN: begin
                if (cnt == '0) begin
                    state_n = CLOSE;
                end else begin
                    cnt_n      = cnt - 1'b1;
                    latch_en_n = en_dec;
                end
            end
            CLOSE: begin
                state_n = ACK;
                ack0_n  = ~grant;
                ack1_n  = grant;
            end
            ACK: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            cap_addr    <= '0;
            grant       <= 1'b1;
            latch_en    <= '0;
            latch_d     <= '0;
            busy        <= 1'b0;
            req_if.ack0 <= 1'b0;
            req_if.ack1 <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            cap_addr    <= cap_addr_n;
            grant       <= grant_n;
            latch_en    <= latch_en_n;
            latch_d     <= latch_d_n;
            busy        <= busy_n;
            req_if.ack0 <= ack0_n;
            req_if.ack1 <= ack1_n;
        end
    end
endmodule

// File: tb/tb_latch_bank_controller.sv
// Bench: two controllers (DEPTH 4 and 3) on shared stimulus, timeline model plus literal checks.
module tb_latch_bank_controller;
    localparam int OC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       req0, req1;
    logic [1:0] addr0, addr1;
    logic [7:0] data0, data1;

    logic [3:0] en_w    [2];
    logic [7:0] d_w     [2];
    logic       ack0_w  [2];
    logic       ack1_w  [2];
    logic       busy_w  [2];
    logic       grant_w [2];

    int tests = 0;
    int fails = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int D = (g == 0) ? 4 : 3;
        latch_bank_controller_if #(.WIDTH(8), .AW(2)) bus ();
        logic [D-1:0] en;
        logic [7:0]   d;
        logic         busy_o, grant_o;
        logic [7:0]   mem [D];

        assign bus.req0  = req0;
        assign bus.req1  = req1;
        assign bus.addr0 = addr0;
        assign bus.addr1 = addr1;
        assign bus.data0 = data0;
        assign bus.data1 = data1;

        latch_bank_controller #(.WIDTH(8), .DEPTH(D), .OPEN_CYCLES(OC)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .req_if   (bus),
            .latch_en (en),
            .latch_d  (d),
            .busy     (busy_o),
            .grant    (grant_o)
        );

        // Transparent latch array behind the controller.
        always @(en or d) begin
            for (int i = 0; i < D; i++) begin
                if (en[i]) mem[i] = d;
            end
        end

        assign en_w[g]    = 4'(en);
        assign d_w[g]     = d;
        assign ack0_w[g]  = bus.ack0;
        assign ack1_w[g]  = bus.ack1;
        assign busy_w[g]  = busy_o;
        assign grant_w[g] = grant_o;
    end

    // Model: mt counts cycles since grant (0 = idle); a write occupies OC+3 cycles after it.
    int         mt;
    logic       mg;
    logic [1:0] ma;
    logic [7:0] md;

    function automatic logic pick(input logic r0, input logic r1, input logic last);
        if (r0 && r1) return !last;
        return r1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mt <= 0;
            mg <= 1'b1;
            md <= 8'h00;
            ma <= 2'd0;
        end else if (mt == 0) begin
            if (req0 || req1) begin
                mt <= 1;
                mg <= pick(req0, req1, mg);
                ma <= pick(req0, req1, mg) ? addr1 : addr0;
                md <= pick(req0, req1, mg) ? data1 : data0;
            end
        end else if (mt == OC + 3) begin
            mt <= 0;
        end else begin
            mt <= mt + 1;
        end
    end

    function automatic logic [3:0] exp_en(input int dep);
        if (mt >= 2 && mt <= OC + 1 && int'(ma) < dep) return 4'(1) << ma;
        return 4'd0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, want, $time);
        end
    endtask

    logic [3:0] pen  [2];
    logic [3:0] ppen [2];
    logic [7:0] pd   [2];
    int         since_rst = 0;
    bit         armed = 1'b0;

    task automatic step();
        @(negedge clk);
        if (reset) begin
            since_rst = 0;
            armed     = 1'b1;
        end else begin
            since_rst++;
        end
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                chk("m_latch_en", 32'(en_w[i]), 32'(exp_en(i == 0 ? 4 : 3)));
                chk("m_latch_d", 32'(d_w[i]), 32'(md));
                chk("m_ack0", 32'(ack0_w[i]), 32'(mt == OC + 3 && !mg));
                chk("m_ack1", 32'(ack1_w[i]), 32'(mt == OC + 3 && mg));
                chk("m_busy", 32'(busy_w[i]), 32'(mt != 0));
                chk("m_grant", 32'(grant_w[i]), 32'(mg));
                chk("onehot0", 32'($onehot0(en_w[i])), 32'd1);
                if (since_rst >= 3 && (en_w[i] != 4'd0 || en_w[i] != pen[i] || pen[i] != ppen[i]))
                    chk("d_stable", 32'(d_w[i]), 32'(pd[i]));
                ppen[i] = pen[i];
                pen[i]  = en_w[i];
                pd[i]   = d_w[i];
            end
        end
    endtask

    int   t0, t1, n, acks;
    bit   got, seen_en;
    logic gseq [4];

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = 2'd0; addr1 = 2'd0;
        data0 = 8'h00; data1 = 8'h00;
        step();
        step();
        chk("rst_en", 32'(en_w[0]), 32'd0);
        chk("rst_d", 32'(d_w[0]), 32'd0);
        chk("rst_ack0", 32'(ack0_w[0]), 32'd0);
        chk("rst_ack1", 32'(ack1_w[0]), 32'd0);
        chk("rst_busy", 32'(busy_w[0]), 32'd0);
        chk("rst_grant", 32'(grant_w[0]), 32'd1);
        reset = 1'b0;
        step();

        // Single write to latch 2
        req0 = 1'b1; addr0 = 2'd2; data0 = 8'hA5;
        step();
        chk("w1_setup_d", 32'(d_w[0]), 32'hA5);
        chk("w1_setup_en", 32'(en_w[0]), 32'h0);
        chk("w1_setup_grant", 32'(grant_w[0]), 32'd0);
        step();
        chk("w1_open1_en", 32'(en_w[0]), 32'b0100);
        step();
        chk("w1_open2_en", 32'(en_w[0]), 32'b0100);
        step();
        chk("w1_close_en", 32'(en_w[0]), 32'h0);
        chk("w1_close_d", 32'(d_w[0]), 32'hA5);
        step();
        chk("w1_ack0", 32'(ack0_w[0]), 32'd1);
        chk("w1_mem2", 32'(g_dut[0].mem[2]), 32'hA5);
        req0 = 1'b0;
        step();
        chk("w1_idle_busy", 32'(busy_w[0]), 32'd0);

        // Simultaneous requests right after reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        req0 = 1'b1; addr0 = 2'd1; data0 = 8'h3C;
        req1 = 1'b1; addr1 = 2'd0; data1 = 8'hC3;
        t0 = -1; t1 = -1;
        for (int c = 1; c <= 30 && t1 < 0; c++) begin
            step();
            if (ack0_w[0] && t0 < 0) begin
                t0 = c;
                chk("sim_first_grant", 32'(grant_w[0]), 32'd0);
                req0 = 1'b0;
            end
            if (ack1_w[0]) begin
                t1 = c;
                req1 = 1'b0;
            end
        end
        chk("sim_ack0_cycle", 32'(t0), 32'd5);
        chk("sim_ack1_gap", 32'(t1 - t0), 32'd6);
        chk("sim_mem1", 32'(g_dut[0].mem[1]), 32'h3C);
        chk("sim_mem0", 32'(g_dut[0].mem[0]), 32'hC3);

        // Fairness with both requests held across four writes
        req0 = 1'b1; addr0 = 2'd3; data0 = 8'h11;
        req1 = 1'b1; addr1 = 2'd2; data1 = 8'h22;
        n = 0;
        for (int c = 0; c < 80 && n < 4; c++) begin
            step();
            if (ack0_w[0] || ack1_w[0]) begin
                gseq[n] = grant_w[0];
                n++;
                if (ack0_w[0]) begin addr0 = 2'd1; data0 = 8'h33; end
                if (ack1_w[0]) begin addr1 = 2'd0; data1 = 8'h44; end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("fair_count", 32'(n), 32'd4);
        chk("fair_g0", 32'(gseq[0]), 32'd0);
        chk("fair_g1", 32'(gseq[1]), 32'd1);
        chk("fair_g2", 32'(gseq[2]), 32'd0);
        chk("fair_g3", 32'(gseq[3]), 32'd1);
        chk("fair_mem3", 32'(g_dut[0].mem[3]), 32'h11);
        chk("fair_mem2", 32'(g_dut[0].mem[2]), 32'h22);
        chk("fair_mem1", 32'(g_dut[0].mem[1]), 32'h33);
        chk("fair_mem0", 32'(g_dut[0].mem[0]), 32'h44);

        // Out-of-range address on the DEPTH=3 instance
        step();
        req1 = 1'b1; addr1 = 2'd3; data1 = 8'h5A;
        got = 1'b0; seen_en = 1'b0;
        for (int c = 1; c <= 20 && !got; c++) begin
            step();
            if (en_w[1] != 4'd0) seen_en = 1'b1;
            if (ack1_w[1]) begin
                got = 1'b1;
                req1 = 1'b0;
                chk("oor_ack_cycle", 32'(c), 32'd5);
            end
        end
        chk("oor_en_zero", 32'(seen_en), 32'd0);
        chk("oor_ack1", 32'(got), 32'd1);
        chk("oor_keep0", 32'(g_dut[1].mem[0]), 32'h44);
        chk("oor_keep1", 32'(g_dut[1].mem[1]), 32'h33);
        chk("oor_keep2", 32'(g_dut[1].mem[2]), 32'h22);
        chk("oor_d4_mem3", 32'(g_dut[0].mem[3]), 32'h5A);

        // Reset during the first OPEN cycle
        step();
        req0 = 1'b1; addr0 = 2'd1; data0 = 8'h77;
        step();
        step();
        chk("ro_open_en", 32'(en_w[0]), 32'b0010);
        reset = 1'b1;
        req0 = 1'b0;
        step();
        chk("ro_en", 32'(en_w[0]), 32'd0);
        chk("ro_busy", 32'(busy_w[0]), 32'd0);
        chk("ro_d", 32'(d_w[0]), 32'd0);
        chk("ro_grant", 32'(grant_w[0]), 32'd1);
        reset = 1'b0;
        acks = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (ack0_w[0] || ack1_w[0]) acks++;
        end
        chk("ro_no_ack", 32'(acks), 32'd0);
        req1 = 1'b1; addr1 = 2'd2; data1 = 8'h99;
        got = 1'b0;
        for (int c = 1; c <= 20 && !got; c++) begin
            step();
            if (ack1_w[0]) begin
                got = 1'b1;
                req1 = 1'b0;
                chk("ro_next_ack_cycle", 32'(c), 32'd5);
            end
        end
        chk("ro_next_ack", 32'(got), 32'd1);
        chk("ro_next_mem", 32'(g_dut[0].mem[2]), 32'h99);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/latch_bank_controller.md
# latch_bank_controller

Write controller and arbiter for a bank of `DEPTH` transparent D latches, each `WIDTH` bits wide. Two requesters share the bank. The block grants one requester at a time with round-robin fairness and captures that requester's address and data. It then sequences the shared latch data bus and the per-latch enables so that data is stable before an enable opens and after it closes. The block sits between the requesting logic and the latch array, which is built from the existing D-latch cells (`clk` is the latch enable, `d` the data input).

## Interface
Parameters:
- `WIDTH`, 8: data width of each latch word.
- `DEPTH`, 4: number of latch words; `AW = $clog2(DEPTH)`, minimum 1.
- `OPEN_CYCLES`, 2: cycles an enable stays high; legal range 1..15.

Ports:
- `clk` input 1: single clock, rising-edge.
- `reset` input 1: synchronous, active-high.
- `req0` / `req1` input 1: write request, level.
- `addr0` / `addr1` input AW: target latch index.
- `data0` / `data1` input WIDTH: write data.
- `ack0` / `ack1` output 1: one-cycle completion pulse.
- `latch_en` output DEPTH: one-hot latch enables, wired to latch `clk` pins.
- `latch_d` output WIDTH: shared data bus, wired to latch `d` pins.
- `busy` output 1: high in every state except IDLE.
- `grant` output 1: index of the current or last granted requester.

## Operation
- Reset values: state IDLE, `latch_en` = 0, `latch_d` = 0, `ack0` = `ack1` = 0, `busy` = 0, `grant` = 1, so requester 0 wins the first tie.
- IDLE
  - If any request is pending, arbitrate.
  - A single request is granted directly.
  - If both requests are pending, the grant goes to the requester that is not `grant`.
  - On grant: capture `addr`/`data` of the winner, update `grant`, go to SETUP.
- SETUP, 1 cycle: `latch_d` = captured data, `latch_en` = 0.
- OPEN, `OPEN_CYCLES` cycles: `latch_en[addr]` = 1, all other bits 0; `latch_d` held.
- CLOSE, 1 cycle: `latch_en` = 0; `latch_d` still held, which gives the latches their hold time.
- ACK, 1 cycle: `ack[grant]` = 1; `latch_d` keeps its value; next state IDLE.
- Requests are captured at grant, so the requester may change addr/data after the grant edge. `req` must be held until `ack`.
- A `req` still high in the cycle after `ack` counts as a new request and is arbitrated normally. The other requester wins if it is pending.
- An out-of-range `addr` (>= `DEPTH`) runs the full sequence with `latch_en` = 0 throughout and is still acked.
- A request that drops before grant is simply not served. There is no abort once granted.
- `latch_en` must never have more than one bit set and must never change in the same cycle as `latch_d`.

## Timing
- Request sampled high in IDLE at edge k:
  - SETUP during cycle k+1.
  - OPEN during cycles k+2 .. k+1+`OPEN_CYCLES`.
  - CLOSE during cycle k+2+`OPEN_CYCLES`.
  - `ack` high during cycle k+3+`OPEN_CYCLES`.
- IDLE is re-entered at k+4+`OPEN_CYCLES`. Back-to-back service is therefore `OPEN_CYCLES`+4 cycles per write.
- All outputs are registered; there is no combinational path from inputs to outputs.
- The OPEN counter is 4 bits. It loads `OPEN_CYCLES`-1 on entry to OPEN and exits when it reaches 0.
- Reset asserted mid-sequence: at the next edge all outputs take their reset values and state becomes IDLE. The interrupted latch word's content is undefined, and no `ack` is issued for it.

## Structure
- Package `latch_ctrl_pkg`:
  - state enum `IDLE`, `SETUP`, `OPEN`, `CLOSE`, `ACK`.
  - counter width constant `OPEN_CNT_W` = 4.
- Sub-module `rr_arbiter2`: combinational two-way round-robin pick from `req0`, `req1` and `grant`. It outputs `valid` and `winner`.
- Everything else (FSM, capture registers, counter, output registers) lives in the top module.

## Test plan
- Reset then single write: `req0`=1, `addr0`=2, `data0`=8'hA5, `OPEN_CYCLES`=2.
  - `latch_d`=A5 from cycle k+1.
  - `latch_en`=4'b0100 during k+2..k+3.
  - `ack0` pulse at k+5.
  - Latch 2 reads A5.
- Simultaneous requests: `req0` and `req1` high together after reset.
  - Requester 0 is served first (`grant`=0).
  - Requester 1 gets `ack1` 6 cycles after `ack0`.
  - Enables never overlap.
- Fairness: both requests held high for 4 transactions.
  - `grant` sequence 0,1,0,1.
  - Each write lands at its own address.
- Out-of-range address with `DEPTH`=3: `addr1`=3.
  - `latch_en` stays 0 for the whole sequence.
  - `ack1` is still pulsed.
  - Latches 0..2 keep their contents.
- Reset in OPEN: assert `reset` in the first OPEN cycle.
  - At the next edge `latch_en`=0, `busy`=0, state IDLE.
  - No ack is issued.
  - A following request completes normally.
- Assertion monitor, active in all tests:
  - `$onehot0(latch_en)` holds every cycle.
  - `latch_d` is stable whenever `latch_en` is nonzero or changed in the previous cycle.
